// File: rtl/cpu_op_sequencer_if.sv
// Request, preload, datapath and response bundle for cpu_op_sequencer.
// master = requester/datapath side, slave = sequencer.
interface cpu_op_sequencer_if #(
    parameter int W     = 16,
    parameter int NREGS = 8
);
    localparam int AW = $clog2(NREGS);

    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_opcode;
    logic [1:0]    req_f0;
    logic          req_cin;
    logic          req_bin;
    logic [AW-1:0] req_rs1;
    logic [AW-1:0] req_rs2;
    logic [AW-1:0] req_rd;

    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [W-1:0]  ld_data;

    logic [3:0]    dp_opcode;
    logic [1:0]    dp_f0;
    logic [W-1:0]  dp_inp1;
    logic [W-1:0]  dp_inp2;
    logic          dp_cin;
    logic          dp_bin;
    logic [W-1:0]  dp_out_wb;

    logic          rsp_valid;
    logic [AW-1:0] rsp_rd;
    logic [W-1:0]  rsp_data;

    modport master (
        output req_valid, req_opcode, req_f0, req_cin, req_bin, req_rs1, req_rs2, req_rd,
        input  req_ready,
        output ld_en, ld_addr, ld_data,
        input  dp_opcode, dp_f0, dp_inp1, dp_inp2, dp_cin, dp_bin,
        output dp_out_wb,
        input  rsp_valid, rsp_rd, rsp_data
    );

    modport slave (
        input  req_valid, req_opcode, req_f0, req_cin, req_bin, req_rs1, req_rs2, req_rd,
        output req_ready,
        input  ld_en, ld_addr, ld_data,
        output dp_opcode, dp_f0, dp_inp1, dp_inp2, dp_cin, dp_bin,
        input  dp_out_wb,
        output rsp_valid, rsp_rd, rsp_data
    );
endinterface

// File: rtl/cpu_op_sequencer.sv
// Operand regfile + issue/wait/writeback sequencer in front of the top_cpu datapath.
// Optional CPU_SEQ_BACK2BACK_EN drops the RESP cycle so capture returns straight to IDLE.
module cpu_op_sequencer #(
    parameter int W      = 16,
    parameter int NREGS  = 8,
    parameter int DP_LAT = 1
) (
    input logic             clk,
    input logic             rst,
    cpu_op_sequencer_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t                   state, state_nxt;
    logic [3:0]               cnt;
    logic [AW-1:0]            rd_q;
    logic [NREGS-1:0][W-1:0]  regs;
    logic                     accept;
    logic                     capture;

    assign accept  = (state == S_IDLE) && bus.req_valid;
    assign capture = (state == S_EXEC) && (cnt == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.req_valid) state_nxt = S_EXEC;
`ifdef CPU_SEQ_BACK2BACK_EN
            S_EXEC: if (cnt == 4'd0) state_nxt = S_IDLE;
`else
            S_EXEC: if (cnt == 4'd0) state_nxt = S_RESP;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // ready is gated by rst so a requester never sees a handshake during reset
    always_comb begin
        bus.req_ready = (state == S_IDLE) && !rst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dp_opcode <= '0;
            bus.dp_f0     <= '0;
            bus.dp_inp1   <= '0;
            bus.dp_inp2   <= '0;
            bus.dp_cin    <= 1'b0;
            bus.dp_bin    <= 1'b0;
            rd_q          <= '0;
            cnt           <= '0;
        end else if (accept) begin
            bus.dp_opcode <= bus.req_opcode;
            bus.dp_f0     <= bus.req_f0;
            bus.dp_inp1   <= regs[bus.req_rs1];
            bus.dp_inp2   <= regs[bus.req_rs2];
            bus.dp_cin    <= bus.req_cin;
            bus.dp_bin    <= bus.req_bin;
            rd_q          <= bus.req_rd;
            cnt           <= 4'(DP_LAT);
        end else if (state == S_EXEC && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_rd    <= '0;
            bus.rsp_data  <= '0;
        end else begin
            bus.rsp_valid <= capture;
            if (capture) begin
                bus.rsp_rd   <= rd_q;
                bus.rsp_data <= bus.dp_out_wb;
            end
        end
    end

    // r0 is never written, so it reads as zero; writeback is last so it beats a same-edge preload
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '0;
        end else begin
            if (bus.ld_en && bus.ld_addr != '0) regs[bus.ld_addr] <= bus.ld_data;
            if (capture && rd_q != '0)          regs[rd_q]        <= bus.dp_out_wb;
        end
    end
endmodule

// File: tb/tb_cpu_op_sequencer.sv
// Directed bench for cpu_op_sequencer with a small ALU stand-in for the top_cpu datapath.
module tb_cpu_op_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    int   t1, t2, pulses;

    cpu_op_sequencer_if #(.W(16), .NREGS(8)) bus ();

    cpu_op_sequencer #(.W(16), .NREGS(8), .DP_LAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] dp_model(input logic [1:0] f0, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        case (f0)
            2'd0:    return a + b;
            2'd1:    return p[15:0];
            2'd2:    return a - b;
            default: return a ^ b;
        endcase
    endfunction

    always_comb bus.dp_out_wb = dp_model(bus.dp_f0, bus.dp_inp1, bus.dp_inp2);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [2:0] a, input logic [15:0] d);
        bus.ld_en = 1'b1; bus.ld_addr = a; bus.ld_data = d;
        @(negedge clk);
        bus.ld_en = 1'b0;
    endtask

    // Called and returns at a negedge; returns in the cycle rsp_valid is high.
    task automatic run_op(input logic [3:0] opc, input logic [1:0] f0, input logic cin, input logic bin,
                          input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd,
                          input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] ed,
                          input bit collide, output int t_rsp);
        int k;
        bus.req_opcode = opc; bus.req_f0 = f0; bus.req_cin = cin; bus.req_bin = bin;
        bus.req_rs1 = rs1; bus.req_rs2 = rs2; bus.req_rd = rd;
        bus.req_valid = 1'b1;
        k = 0;
        while (!bus.req_ready && k < 20) begin @(negedge clk); k++; end
        if (!bus.req_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("dp_inp1",   32'(bus.dp_inp1),   32'(e1));
        chk("dp_inp2",   32'(bus.dp_inp2),   32'(e2));
        chk("dp_f0",     32'(bus.dp_f0),     32'(f0));
        chk("dp_opcode", 32'(bus.dp_opcode), 32'(opc));
        chk("dp_cin",    32'(bus.dp_cin),    32'(cin));
        chk("dp_bin",    32'(bus.dp_bin),    32'(bin));
        chk("ready_exec", 32'(bus.req_ready), 32'd0);
        k = 0;
        while (!bus.rsp_valid && k < 20) begin
            if (collide && k == 1) begin bus.ld_en = 1'b1; bus.ld_addr = 3'd3; bus.ld_data = 16'd7; end
            @(negedge clk);
            bus.ld_en = 1'b0;
            k++;
        end
        chk("rsp_latency", 32'(k), 32'd2);
        chk("rsp_rd",   32'(bus.rsp_rd),   32'(rd));
        chk("rsp_data", 32'(bus.rsp_data), 32'(ed));
        chk("dp_hold",  32'(bus.dp_inp1),  32'(e1));
        t_rsp = cyc;
    endtask

    initial begin
        int t;
        bus.req_valid = 1'b0; bus.req_opcode = '0; bus.req_f0 = '0; bus.req_cin = 1'b0; bus.req_bin = 1'b0;
        bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_rd = '0;
        bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;

        @(negedge clk); @(negedge clk);
        chk("rst_ready",     32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_dp_inp1",   32'(bus.dp_inp1),   32'd0);
        rst = 1'b0;
        #1 chk("ready_after_rst", 32'(bus.req_ready), 32'd1);

        preload(3'd1, 16'd120);
        preload(3'd2, 16'd10);

        // basic writeback, then read r3 back as an operand
        run_op(4'b0001, 2'b00, 1'b1, 1'b0, 3'd1, 3'd2, 3'd3, 16'd120, 16'd10, 16'd130, 1'b0, t);
        run_op(4'b0001, 2'b00, 1'b0, 1'b1, 3'd3, 3'd2, 3'd5, 16'd130, 16'd10, 16'd140, 1'b0, t);

        // f0 sweep: sum, product, difference, xor of 120 and 10
        run_op(4'b0001, 2'b00, 1'b0, 1'b0, 3'd1, 3'd2, 3'd6, 16'd120, 16'd10, 16'd130,  1'b0, t);
        run_op(4'b0001, 2'b01, 1'b0, 1'b0, 3'd1, 3'd2, 3'd6, 16'd120, 16'd10, 16'd1200, 1'b0, t);
        run_op(4'b0001, 2'b10, 1'b0, 1'b0, 3'd1, 3'd2, 3'd6, 16'd120, 16'd10, 16'd110,  1'b0, t);
        run_op(4'b0001, 2'b11, 1'b0, 1'b0, 3'd1, 3'd2, 3'd6, 16'd120, 16'd10, 16'd114,  1'b0, t);

        // rd=0 still responds but r0 stays zero; preload of r0 is discarded
        run_op(4'b0001, 2'b00, 1'b0, 1'b0, 3'd1, 3'd2, 3'd0, 16'd120, 16'd10, 16'd130, 1'b0, t);
        run_op(4'b0001, 2'b00, 1'b0, 1'b0, 3'd0, 3'd2, 3'd6, 16'd0,   16'd10, 16'd10,  1'b0, t);
        @(negedge clk);
        preload(3'd0, 16'd55);
        run_op(4'b0001, 2'b00, 1'b0, 1'b0, 3'd0, 3'd1, 3'd6, 16'd0, 16'd120, 16'd120, 1'b0, t);

        // preload of r3=7 on the capture edge loses to the writeback of 130
        preload(3'd3, 16'd0);
        run_op(4'b0001, 2'b00, 1'b0, 1'b0, 3'd1, 3'd2, 3'd3, 16'd120, 16'd10, 16'd130, 1'b1, t);
        run_op(4'b0001, 2'b00, 1'b0, 1'b0, 3'd3, 3'd0, 3'd6, 16'd130, 16'd0,  16'd130, 1'b0, t);

        // back-to-back: r3=r1+r2 then r4=r3+r2, spacing of rsp_valid pulses
        run_op(4'b0001, 2'b00, 1'b0, 1'b0, 3'd1, 3'd2, 3'd3, 16'd120, 16'd10, 16'd130, 1'b0, t1);
        run_op(4'b0001, 2'b00, 1'b0, 1'b0, 3'd3, 3'd2, 3'd4, 16'd130, 16'd10, 16'd140, 1'b0, t2);
`ifdef CPU_SEQ_BACK2BACK_EN
        chk("b2b_spacing", 32'(t2 - t1), 32'd3);
`else
        chk("b2b_spacing", 32'(t2 - t1), 32'd4);
`endif
        run_op(4'b0001, 2'b00, 1'b0, 1'b0, 3'd4, 3'd0, 3'd6, 16'd140, 16'd0, 16'd140, 1'b0, t);

        // reset during EXEC drops the operation
        @(negedge clk); @(negedge clk);
        bus.req_opcode = 4'b0001; bus.req_f0 = 2'b00; bus.req_cin = 1'b1; bus.req_bin = 1'b1;
        bus.req_rs1 = 3'd1; bus.req_rs2 = 3'd2; bus.req_rd = 3'd7; bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("pre_rst_dp_inp1", 32'(bus.dp_inp1), 32'd120);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready",     32'(bus.req_ready), 32'd0);
        chk("mid_rst_dp_inp1",   32'(bus.dp_inp1),   32'd0);
        chk("mid_rst_dp_inp2",   32'(bus.dp_inp2),   32'd0);
        chk("mid_rst_dp_opcode", 32'(bus.dp_opcode), 32'd0);
        chk("mid_rst_dp_cin",    32'(bus.dp_cin),    32'd0);
        chk("mid_rst_rsp_data",  32'(bus.rsp_data),  32'd0);
        chk("mid_rst_rsp_rd",    32'(bus.rsp_rd),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) pulses++;
        end
        chk("post_rst_no_rsp", 32'(pulses), 32'd0);
        run_op(4'b0001, 2'b00, 1'b0, 1'b0, 3'd7, 3'd1, 3'd6, 16'd0, 16'd0, 16'd0, 1'b0, t);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/cpu_op_sequencer.md
# cpu_op_sequencer

Sequencer that feeds the `top_cpu` ALU/multiplier datapath from a small operand register file. It accepts one operation request at a time over a valid/ready handshake and reads the two source registers. It drives the datapath controls (`opcode`, `f0`, `cin`, `bin`) and operands, waits a fixed datapath latency, then captures `out_wb` into the destination register and reports completion. It sits between the instruction/request source and the `top_cpu` instance, replacing the hand-driven stimulus used at top level today.

## Interface
Parameters:
- `W`, 16, datapath and register width.
- `NREGS`, 8, register count (power of two; index width `AW = $clog2(NREGS)`).
- `DP_LAT`, 1, extra cycles to wait after issue before sampling `dp_out_wb`. Legal range is 0..15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept a request.
- `req_opcode`  in  4  datapath opcode (demux select).
- `req_f0`  in  2  multiplier select line.
- `req_cin`, `req_bin`  in  1 each  carry-in / borrow-in.
- `req_rs1`, `req_rs2`, `req_rd`  in  AW each  source and destination register indices.
- `ld_en`  in  1  direct register preload strobe.
- `ld_addr`  in  AW  preload register index.
- `ld_data`  in  W  preload value.
- `dp_opcode`  out  4  registered drive to datapath.
- `dp_f0`  out  2  registered drive to datapath.
- `dp_inp1`, `dp_inp2`  out  W each  registered operands.
- `dp_cin`, `dp_bin`  out  1 each  registered carry-in / borrow-in.
- `dp_out_wb`  in  W  datapath writeback result.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rd`  out  AW  destination index of the completed operation.
- `rsp_data`  out  W  value written back.

## Operation
- Register file: `NREGS` x `W`. Register r0 reads as 0, and writes to it are discarded (both writeback and preload).
- States: IDLE, EXEC, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, the request is accepted: latch `req_rd`, load `dp_*` from the request fields and from `regs[rs1]` / `regs[rs2]`, load the counter with `DP_LAT`, and go to EXEC.
- EXEC:
  - `req_ready`=0 and `dp_*` are held stable.
  - If the counter is nonzero, decrement it.
  - If the counter is 0, capture `dp_out_wb`: write `regs[rd]` and `rsp_data`, set `rsp_rd`, and go to RESP.
- RESP: `rsp_valid`=1 and `req_ready`=0; the next edge goes to IDLE.
- `req_ready` is a combinational decode of the state. It is 0 while `rst` is high.
- `rsp_valid` is registered.
- Preload:
  - `ld_en` writes `regs[ld_addr]` on any edge, in any state.
  - If a preload and a writeback target the same register on the same edge, the writeback wins.
- Operands are sampled at accept. A preload during EXEC does not change `dp_inp1` / `dp_inp2`.
- `rs1`, `rs2` and `rd` may be equal. Operands are read before the writeback.
- All values are raw W-bit; the sequencer does no arithmetic and no sign handling.
- Reset (any state):
  - State goes to IDLE.
  - The register file, all `dp_*`, `rsp_valid`, `rsp_rd` and `rsp_data` go to 0.
  - Any in-flight operation is dropped with no writeback and no `rsp_valid`.

## Timing
- Accept edge is E0. `dp_*` are valid from E0 until the capture edge, E0+DP_LAT+1.
- `rsp_valid` is high for the one cycle after the capture edge.
- `req_ready` returns high after E0+DP_LAT+2.
- Default build: one operation per DP_LAT+3 cycles.
- A request held with `req_valid` while `req_ready`=0 is not consumed. The requester must hold its fields stable until accepted.

## Configuration
- `CPU_SEQ_BACK2BACK_EN`:
  - Defined: the RESP state is removed. The capture edge goes directly to IDLE, and `rsp_valid` and `req_ready` are high in the same cycle. A request accepted in that cycle reads the just-written value.
    - Throughput is one operation per DP_LAT+2 cycles.
  - Undefined: the RESP cycle is present as described above.

## Test plan
- Basic write-back:
  - Stimulus: preload r1=120, r2=10. Request opcode 0001, f0=00, rs1=1, rs2=2, rd=3, DP_LAT=1. The bench datapath model returns `inp1+inp2`.
  - Required: `dp_inp1`=120 and `dp_inp2`=10 from E0. `rsp_valid` appears after E0+2 with `rsp_rd`=3 and `rsp_data`=130. r3 reads 130 on the next request.
- f0 pass-through: sweep f0=00/01/10/11 with the same operands. `dp_f0` must equal the request value each time, and each `rsp_data` must equal the model output for that f0.
- r0 handling:
  - rd=0: the response is still issued with `rsp_data`=model value, but r0 stays 0.
  - Preload of r0=55: a subsequent rs1=0 drives `dp_inp1`=0.
- Preload/writeback collision: `ld_en` with `ld_addr`=3, `ld_data`=7 on the capture edge of an operation writing r3=130. r3 must read 130.
- Reset mid-operation: assert `rst` during EXEC. `rsp_valid` never pulses, `rd` is unchanged (0), all outputs are 0, and `req_ready`=1 after release.
- Back-to-back:
  - With `CPU_SEQ_BACK2BACK_EN`, r3 = r1+r2 followed by r4 = r3+r2 gives r4=140 and a 3-cycle spacing between `rsp_valid` pulses.
  - Without the macro, the spacing is 4 cycles.
